// File: rtl/z_req_encoder_16_pkg.sv
// Shared sizing and search-mode constants for the 16-line request encoder.
package z_req_encoder_16_pkg;

   localparam int Z_ENC_N     = 16;
   localparam int Z_ENC_W     = 4;
   localparam int Z_ENC_FIXED = 0;
   localparam int Z_ENC_RR    = 1;

   typedef logic [Z_ENC_N-1:0] req_vec_t;
   typedef logic [Z_ENC_W-1:0] req_idx_t;

endpackage

// File: rtl/z_find_first_16.sv
// Combinational search: lowest set index at or above start, else the lowest set index overall.
module z_find_first_16
   import z_req_encoder_16_pkg::*;
(
   input  logic [Z_ENC_N-1:0] vec,
   input  logic [Z_ENC_W-1:0] start,
   output logic [Z_ENC_W-1:0] idx,
   output logic               found
);

   req_vec_t ge_start;
   req_vec_t upper;
   req_idx_t idx_hi;
   req_idx_t idx_lo;
   logic     found_hi;

   generate
      for (genvar gi = 0; gi < Z_ENC_N; gi++) begin : g_mask
         assign ge_start[gi] = (Z_ENC_W'(gi) >= start);
      end
   endgenerate

   assign upper = vec & ge_start;

   // Scan downward so the last hit written is the lowest index.
   always_comb begin
      idx_hi   = '0;
      idx_lo   = '0;
      found_hi = 1'b0;
      for (int i = Z_ENC_N - 1; i >= 0; i--) begin
         if (upper[i]) begin
            idx_hi   = req_idx_t'(i);
            found_hi = 1'b1;
         end
         if (vec[i]) begin
            idx_lo = req_idx_t'(i);
         end
      end
   end

   assign idx   = found_hi ? idx_hi : idx_lo;
   assign found = |vec;

endmodule

// File: rtl/z_req_encoder_16.sv
// Captures request lines into a pending set and issues one index at a time over valid/ready.
module z_req_encoder_16
   import z_req_encoder_16_pkg::*;
#(
   parameter int RR = Z_ENC_FIXED
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic [Z_ENC_N-1:0] req_in,
   input  logic               en,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [Z_ENC_W-1:0] out_sel,
   output logic [Z_ENC_N-1:0] pending,
   output logic               busy
);

   req_vec_t pending_reg;
   req_vec_t pending_next;
   req_vec_t clr_mask;
   req_idx_t out_sel_reg;
   req_idx_t rr_ptr_reg;
   req_idx_t start_idx;
   req_idx_t found_idx;
   logic     out_valid_reg;
   logic     found;
   logic     load;

   // Search only the registered set; fresh requests wait one cycle.
   assign start_idx = (RR == Z_ENC_RR) ? rr_ptr_reg : '0;

   z_find_first_16 u_find (
      .vec   (pending_reg),
      .start (start_idx),
      .idx   (found_idx),
      .found (found)
   );

   assign load = en & found & (~out_valid_reg | out_ready);

   generate
      for (genvar gi = 0; gi < Z_ENC_N; gi++) begin : g_clr
         assign clr_mask[gi] = load & (found_idx == Z_ENC_W'(gi));
      end
   endgenerate

   // A request arriving on the bit being issued survives the clear.
   assign pending_next = (pending_reg & ~clr_mask) | req_in;

   always_ff @(posedge clock) begin
      if (reset) begin
         pending_reg   <= '0;
         out_sel_reg   <= '0;
         out_valid_reg <= 1'b0;
         rr_ptr_reg    <= '0;
      end else begin
         pending_reg <= pending_next;
         if (load) begin
            out_sel_reg   <= found_idx;
            out_valid_reg <= 1'b1;
            rr_ptr_reg    <= found_idx + req_idx_t'(1);
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_sel   = out_sel_reg;
   assign pending   = pending_reg;
   assign busy      = (|pending_reg) | out_valid_reg;

endmodule
